// File: rtl/payment_gate_controller.sv
// payment_gate_controller: collects coin/card payment for a computed fee, reports change or refund, opens exit gate
// Ports:
//   clk, reset (async, active-low)
//   fee/calculation_done            fee strobe from the fee calculator, taken only in IDLE
//   coin_valid/coin_value           accepted coin strobe and its value (zero-extended)
//   card_valid/card_ok              card authorisation strobe and result
//   cancel                          driver abort
//   busy                            high whenever a transaction is in progress
//   paid_total                      running amount tendered
//   change_due/change_valid         change or refund amount with its one-cycle qualifier
//   payment_done/payment_failed     one-cycle outcome pulses
//   card_declined                   one-cycle pulse on a declined card
//   gate_open                       barrier drive, high GATE_OPEN_CYCLES cycles after success
// Optional: define REVENUE_LOG_EN to add revenue_total (wrapping) and txn_count (saturating).
module payment_gate_controller #(
    parameter int FEE_WIDTH        = 32,
    parameter int TIMEOUT_CYCLES   = 1000,
    parameter int GATE_OPEN_CYCLES = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FEE_WIDTH-1:0] fee,
    input  logic                 calculation_done,
    input  logic                 coin_valid,
    input  logic [7:0]           coin_value,
    input  logic                 card_valid,
    input  logic                 card_ok,
    input  logic                 cancel,
    output logic                 busy,
    output logic [FEE_WIDTH-1:0] paid_total,
    output logic [FEE_WIDTH-1:0] change_due,
    output logic                 change_valid,
    output logic                 payment_done,
    output logic                 payment_failed,
    output logic                 card_declined,
    output logic                 gate_open
`ifdef REVENUE_LOG_EN
    ,
    output logic [31:0]          revenue_total,
    output logic [15:0]          txn_count
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GATE_OPEN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, AWAIT_PAY, SETTLE, GATE, FAIL} state_t;

    state_t               state;
    logic [FEE_WIDTH-1:0] fee_reg;
    logic [TW-1:0]        timer;
    logic [GW-1:0]        gate_cnt;
    logic [FEE_WIDTH:0]   coin_sum;
    logic [FEE_WIDTH-1:0] coin_total;

    // one extra bit catches the carry so the running total clamps at all-ones
    assign coin_sum   = {1'b0, paid_total} + (FEE_WIDTH + 1)'(coin_value);
    assign coin_total = coin_sum[FEE_WIDTH] ? '1 : coin_sum[FEE_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            fee_reg        <= '0;
            timer          <= '0;
            gate_cnt       <= '0;
            busy           <= 1'b0;
            paid_total     <= '0;
            change_due     <= '0;
            change_valid   <= 1'b0;
            payment_done   <= 1'b0;
            payment_failed <= 1'b0;
            card_declined  <= 1'b0;
            gate_open      <= 1'b0;
`ifdef REVENUE_LOG_EN
            revenue_total  <= '0;
            txn_count      <= '0;
`endif
        end else begin
            change_valid   <= 1'b0;
            payment_done   <= 1'b0;
            payment_failed <= 1'b0;
            card_declined  <= 1'b0;
            case (state)
                IDLE: if (calculation_done) begin
                    fee_reg    <= fee;
                    paid_total <= '0;
                    timer      <= '0;
                    busy       <= 1'b1;
                    state      <= (fee == '0) ? SETTLE : AWAIT_PAY;
                end
                // cancel beats card beats coin; losers in the same cycle are dropped
                AWAIT_PAY: if (cancel) begin
                    state <= FAIL;
                end else if (card_valid && card_ok) begin
                    paid_total <= fee_reg;
                    state      <= SETTLE;
                end else if (card_valid) begin
                    card_declined <= 1'b1;
                    timer         <= '0;
                end else if (coin_valid) begin
                    paid_total <= coin_total;
                    timer      <= '0;
                    if (coin_total >= fee_reg) state <= SETTLE;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state <= FAIL;
                end else begin
                    timer <= timer + 1'b1;
                end
                SETTLE: begin
                    change_due   <= paid_total - fee_reg;
                    change_valid <= 1'b1;
                    payment_done <= 1'b1;
                    gate_open    <= 1'b1;
                    gate_cnt     <= '0;
                    state        <= GATE;
`ifdef REVENUE_LOG_EN
                    revenue_total <= revenue_total + 32'(fee_reg);
                    txn_count     <= (txn_count == 16'hFFFF) ? txn_count : txn_count + 1'b1;
`endif
                end
                // gate_open was raised on the SETTLE edge, so that edge is cycle one
                GATE: if (gate_cnt == GW'(GATE_OPEN_CYCLES - 1)) begin
                    gate_open <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else begin
                    gate_cnt <= gate_cnt + 1'b1;
                end
                FAIL: begin
                    change_due     <= paid_total;
                    change_valid   <= 1'b1;
                    payment_failed <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    gate_open <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
